icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl.sv | 143 ++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill sequencer: fetches one line word by word on a miss,
// then writes its tag. Also clears every tag on a flush request.
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 32,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      i_pc,
  input  logic             i_miss,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_mem_req_valid,
  input  logic             i_mem_req_ready,
  output logic [31:0]      o_mem_req_addr,
  input  logic             i_mem_resp_valid,
  input  logic [31:0]      i_mem_resp_data,
  output logic             o_fill_we,
  output logic [31:0]      o_fill_addr,
  output logic [31:0]      o_fill_data,
  output logic             o_tag_we,
  output logic [IDX_W-1:0] o_tag_index,
  output logic [23:0]      o_tag_value,
  output logic             o_busy,
  output logic             o_refill_done
);

  // state | meaning: IDLE wait for miss/flush | REQ read request | WAIT read data
  //                  TAG write line tag | DONE completion pulse | FLUSH clear all tags
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_TAG, S_DONE, S_FLUSH} state_t;

  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int OFF_W   = WORD_W + 2;
  localparam int TAG_LSB = 9 - OFF_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_LINE = IDX_W'(NUM_LINES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [31-OFF_W:0]   r_line;
  logic [WORD_W-1:0]   r_word_cnt;
  logic [IDX_W-1:0]    r_flush_cnt;
  logic                r_flush_pend;
  logic                w_last_word;
  logic                w_last_line;
  logic                w_start_flush;
  logic                w_start_refill;
  logic [31:0]         w_word_addr;
  logic                w_unused_pc;

  assign w_unused_pc    = ^i_pc[OFF_W-1:0];
  assign w_last_word    = (r_word_cnt == LAST_WORD);
  assign w_last_line    = (r_flush_cnt == LAST_LINE);
  assign w_start_flush  = (r_state == S_IDLE) && (i_flush || r_flush_pend);
  assign w_start_refill = (r_state == S_IDLE) && !w_start_flush && i_miss;
  assign w_word_addr    = {r_line, r_word_cnt, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Counters hold at their final value; they are re-armed when the next job starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line       <= '0;
      r_word_cnt   <= '0;
      r_flush_cnt  <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_start_flush) begin
        r_flush_pend <= 1'b0;
        r_flush_cnt  <= '0;
      end else if (r_state != S_IDLE && i_flush) begin
        r_flush_pend <= 1'b1;
      end
      if (w_start_refill) begin
        r_line     <= i_pc[31:OFF_W];
        r_word_cnt <= '0;
      end
      if (r_state == S_WAIT && i_mem_resp_valid && !w_last_word)
        r_word_cnt <= r_word_cnt + WORD_W'(1);
      if (r_state == S_FLUSH && !w_last_line)
        r_flush_cnt <= r_flush_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_flush)       w_next = S_FLUSH;
        else if (w_start_refill) w_next = S_REQ;
      end
      S_REQ:   if (i_mem_req_ready) w_next = S_WAIT;
      S_WAIT:  if (i_mem_resp_valid) w_next = w_last_word ? S_TAG : S_REQ;
      S_TAG:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_FLUSH: if (w_last_line) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy          = (r_state != S_IDLE);
    o_stall         = i_miss | o_busy;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_fill_we       = 1'b0;
    o_fill_addr     = '0;
    o_fill_data     = '0;
    o_tag_we        = 1'b0;
    o_tag_index     = '0;
    o_tag_value     = '0;
    o_refill_done   = 1'b0;
    case (r_state)
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = w_word_addr;
      end
      S_WAIT: begin
        if (i_mem_resp_valid) begin
          o_fill_we   = 1'b1;
          o_fill_addr = w_word_addr;
          o_fill_data = i_mem_resp_data;
        end
      end
      S_TAG: begin
        o_tag_we    = 1'b1;
        o_tag_index = r_line[IDX_W-1:0];
        o_tag_value = {1'b1, r_line[31-OFF_W:TAG_LSB]};
      end
      S_DONE:  o_refill_done = 1'b1;
      S_FLUSH: begin
        o_tag_we    = 1'b1;
        o_tag_index = r_flush_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: job-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_icache_refill_ctrl;
  localparam int LW = 4;
  localparam int NL = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_pc;
  logic        i_miss, i_flush, i_mem_req_ready, i_mem_resp_valid;
  logic [31:0] i_mem_resp_data;
  logic        o_stall, o_mem_req_valid, o_fill_we, o_tag_we, o_busy, o_refill_done;
  logic [31:0] o_mem_req_addr, o_fill_addr, o_fill_data;
  logic [4:0]  o_tag_index;
  logic [23:0] o_tag_value;

  icache_refill_ctrl #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset), .i_pc(i_pc), .i_miss(i_miss), .i_flush(i_flush),
    .o_stall(o_stall), .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_addr(o_mem_req_addr), .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_data(i_mem_resp_data), .o_fill_we(o_fill_we), .o_fill_addr(o_fill_addr),
    .o_fill_data(o_fill_data), .o_tag_we(o_tag_we), .o_tag_index(o_tag_index),
    .o_tag_value(o_tag_value), .o_busy(o_busy), .o_refill_done(o_refill_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a job (0 none, 1 refill, 2 flush) and its progress along a fixed schedule.
  // Refill: even step = request word step/2, odd step = await that word, 2*LW = tag, 2*LW+1 = done.
  // Flush: step 0..NL-1 = clear that index, NL = done.
  int          m_kind = 0;
  int          m_p    = 0;
  logic [27:0] m_line = '0;
  bit          m_fpend = 1'b0;

  logic [31:0] req_log[$];
  logic [4:0]  tagi_log[$];
  logic [23:0] tagv_log[$];
  int          fill_cnt = 0, done_cnt = 0, watch_cnt = 0;
  logic [31:0] watch_addr = '0;
  bit          last_hs = 1'b0, auto_resp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic        e_busy, e_stall, e_rv, e_fwe, e_twe, e_done;
    logic [31:0] e_addr, e_fa, e_fd, a;
    logic [4:0]  e_ti;
    logic [23:0] e_tv;
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk); #1;
      e_busy = (m_kind != 0);
      e_stall = i_miss | e_busy;
      e_rv = 0; e_fwe = 0; e_twe = 0; e_done = 0;
      e_addr = '0; e_fa = '0; e_fd = '0; e_ti = '0; e_tv = '0;
      if (m_kind == 1) begin
        if (m_p < 2*LW) begin
          a = {m_line, 4'b0000} + 32'(4 * (m_p / 2));
          if (m_p % 2 == 0) begin
            e_rv = 1; e_addr = a;
          end else if (i_mem_resp_valid) begin
            e_fwe = 1; e_fa = a; e_fd = i_mem_resp_data;
          end
        end else if (m_p == 2*LW) begin
          e_twe = 1; e_ti = 5'(m_line % NL); e_tv = {1'b1, m_line[27:5]};
        end else e_done = 1;
      end else if (m_kind == 2) begin
        if (m_p < NL) begin e_twe = 1; e_ti = 5'(m_p); end
        else e_done = 1;
      end
      chk("stall", o_stall, e_stall);
      chk("busy", o_busy, e_busy);
      chk("req_valid", o_mem_req_valid, e_rv);
      chk("fill_we", o_fill_we, e_fwe);
      chk("tag_we", o_tag_we, e_twe);
      chk("refill_done", o_refill_done, e_done);
      if (e_rv || m_kind == 0) chk("req_addr", o_mem_req_addr, e_addr);
      if (e_fwe || m_kind == 0) begin
        chk("fill_addr", o_fill_addr, e_fa);
        chk("fill_data", o_fill_data, e_fd);
      end
      if (e_twe || m_kind == 0) begin
        chk("tag_index", o_tag_index, e_ti);
        chk("tag_value", o_tag_value, e_tv);
      end
      last_hs = o_mem_req_valid & i_mem_req_ready;
      if (last_hs) req_log.push_back(o_mem_req_addr);
      if (o_fill_we) fill_cnt++;
      if (o_tag_we) begin tagi_log.push_back(o_tag_index); tagv_log.push_back(o_tag_value); end
      if (o_refill_done) done_cnt++;
      if (o_mem_req_valid && o_mem_req_addr == watch_addr) watch_cnt++;
      if (reset) begin
        m_kind = 0; m_p = 0; m_fpend = 0;
      end else begin
        if (m_kind != 0 && i_flush) m_fpend = 1;
        case (m_kind)
          0: if (i_flush || m_fpend) begin m_kind = 2; m_p = 0; m_fpend = 0; end
             else if (i_miss) begin m_kind = 1; m_p = 0; m_line = i_pc[31:4]; end
          1: if (m_p < 2*LW) begin
               if ((m_p % 2 == 0) ? i_mem_req_ready : i_mem_resp_valid) m_p++;
             end else if (m_p == 2*LW) m_p++;
             else m_kind = 0;
          default: if (m_p < NL) m_p++; else m_kind = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (auto_resp) begin
      i_mem_resp_valid = last_hs;
      i_mem_resp_data  = $urandom;
    end
  endtask

  task automatic clear_logs();
    req_log.delete(); tagi_log.delete(); tagv_log.delete();
    fill_cnt = 0; done_cnt = 0; watch_cnt = 0;
  endtask

  task automatic run_until_done(input int n, input int budget);
    int i = 0;
    while (done_cnt < n && i < budget) begin step(); i++; end
    chk("done_wait", (done_cnt >= n), 1);
  endtask

  task automatic chk_flush_run(input string nm, input int off);
    bit ok = 1'b1;
    for (int i = 0; i < NL; i++) begin
      if (tagi_log.size() <= off + i) ok = 1'b0;
      else if (tagi_log[off+i] != 5'(i) || tagv_log[off+i] != 24'h0) ok = 1'b0;
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    int n;
    reset = 1; i_pc = '0; i_miss = 0; i_flush = 0;
    i_mem_req_ready = 0; i_mem_resp_valid = 0; i_mem_resp_data = '0;
    step(); step();
    reset = 0;
    chk("rst_busy", o_busy, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_req_valid", o_mem_req_valid, 0);
    chk("rst_tag_we", o_tag_we, 0);
    auto_resp = 1;

    // single refill, ready always high, one-cycle response
    clear_logs();
    i_pc = 32'h0000_1234; i_miss = 1; i_mem_req_ready = 1;
    step(); i_miss = 0;
    run_until_done(1, 40);
    repeat (3) step();
    chk("s1_req_cnt", req_log.size(), 4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      chk("s1_req_addr", req_log[i], 32'h1230 + 32'(4*i));
    chk("s1_fill_cnt", fill_cnt, 4);
    chk("s1_tag_cnt", tagi_log.size(), 1);
    if (tagi_log.size() > 0) begin
      chk("s1_tag_index", tagi_log[0], 5'h03);
      chk("s1_tag_value", tagv_log[0], 24'h800009);
    end
    chk("s1_done_cnt", done_cnt, 1);

    // ready held low for five REQ cycles
    clear_logs();
    watch_addr = 32'h1230;
    i_pc = 32'h0000_1230; i_miss = 1; i_mem_req_ready = 0;
    step(); i_miss = 0;
    repeat (4) step();
    step(); i_mem_req_ready = 1;
    run_until_done(1, 40);
    repeat (2) step();
    chk("s2_addr_stable", watch_cnt, 6);
    n = 0;
    foreach (req_log[i]) if (req_log[i] == 32'h1230) n++;
    chk("s2_single_req", n, 1);
    chk("s2_req_cnt", req_log.size(), 4);

    // flush from IDLE
    clear_logs();
    i_flush = 1;
    step(); i_flush = 0;
    run_until_done(1, 50);
    repeat (2) step();
    chk("s3_tag_cnt", tagi_log.size(), 32);
    chk_flush_run("s3_flush_seq", 0);
    chk("s3_done_cnt", done_cnt, 1);

    // flush arriving during WAIT of a refill
    clear_logs();
    i_pc = 32'h0000_2040; i_miss = 1;
    step(); i_miss = 0;
    step(); i_flush = 1;
    step(); i_flush = 0;
    run_until_done(2, 80);
    repeat (2) step();
    chk("s4_tag_cnt", tagi_log.size(), 33);
    if (tagi_log.size() > 0) begin
      chk("s4_first_index", tagi_log[0], 5'h04);
      chk("s4_first_value", tagv_log[0], 24'h800010);
    end
    chk_flush_run("s4_flush_seq", 1);
    chk("s4_fill_cnt", fill_cnt, 4);
    chk("s4_done_cnt", done_cnt, 2);

    // reset after the second fill, then stray responses
    clear_logs();
    i_pc = 32'h0000_3000; i_miss = 1;
    step(); i_miss = 0;
    n = 0;
    while (fill_cnt < 2 && n < 20) begin step(); n++; end
    chk("s5_fill_wait", (fill_cnt >= 2), 1);
    reset = 1;
    step(); reset = 0; auto_resp = 0;
    chk("s5_busy_after_rst", o_busy, 0);
    i_mem_resp_valid = 1;
    repeat (4) step();
    i_mem_resp_valid = 0;
    repeat (2) step();
    chk("s5_fill_cnt", fill_cnt, 2);
    chk("s5_tag_cnt", tagi_log.size(), 0);
    auto_resp = 1;

    // miss and flush together: flush first, then the refill
    clear_logs();
    i_pc = 32'h0000_4FF0; i_miss = 1; i_flush = 1;
    step(); i_flush = 0;
    n = 0;
    while (tagi_log.size() < 33 && n < 120) begin step(); n++; end
    i_miss = 0;
    run_until_done(2, 10);
    repeat (3) step();
    chk("s6_tag_cnt", tagi_log.size(), 33);
    chk_flush_run("s6_flush_seq", 0);
    if (tagi_log.size() > 32) begin
      chk("s6_refill_index", tagi_log[32], 5'h1F);
      chk("s6_refill_value", tagv_log[32], 24'h800027);
    end
    chk("s6_first_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h4FF0);
    chk("s6_done_cnt", done_cnt, 2);

    // randomized traffic, including stray responses, flushes and resets
    auto_resp = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      reset            = ($urandom_range(0, 299) == 0);
      i_pc             = $urandom;
      i_miss           = ($urandom_range(0, 2) == 0);
      i_flush          = ($urandom_range(0, 79) == 0);
      i_mem_req_ready  = ($urandom_range(0, 2) != 0);
      i_mem_resp_valid = ($urandom_range(0, 2) == 0);
      i_mem_resp_data  = $urandom;
    end
    step();
    reset = 0; i_miss = 0; i_flush = 0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
